// File: rtl/cnn_row_load_ctrl.sv
// cnn_row_load_ctrl: sequencer between the SPI command byte and the CNN row
// registers. A start command clears all rows, loads them one per cycle,
// pulses the CNN start, waits for CNN done and latches the prediction.
// Optional feature: define CNN_CTRL_TIMEOUT_EN to bound the WAIT state by
// TIMEOUT_CYC cycles and enter ERR on expiry.
module cnn_row_load_ctrl #(
    parameter int                     DATAWIDTH_BUS = 8,
    parameter int                     NUM_ROWS      = 8,
    parameter logic [DATAWIDTH_BUS-1:0] START_CODE  = 8'hA5,
    parameter int                     TIMEOUT_CYC   = 1024
) (
    input  logic                     CNNCtrl_CLOCK_50,
    input  logic                     CNNCtrl_Reset_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] CNNCtrl_Cmd_InBUS,
    input  logic                     CNNCtrl_CNNDone_In,
    input  logic [DATAWIDTH_BUS-1:0] CNNCtrl_Predict_InBUS,
    output logic                     CNNCtrl_RegReset_InHigh,
    output logic [NUM_ROWS-1:0]      CNNCtrl_Load_InLow,
    output logic                     CNNCtrl_CNNStart_Out,
    output logic                     CNNCtrl_Busy_Out,
    output logic                     CNNCtrl_Done_Out,
    output logic                     CNNCtrl_Error_Out,
    output logic [DATAWIDTH_BUS-1:0] CNNCtrl_Result_OutBUS
);

    localparam int RCW = $clog2(NUM_ROWS) + 1;
    localparam logic [RCW-1:0] ROW_LAST = RCW'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_START, S_WAIT, S_DONE, S_ERR
    } state_t;

    state_t                     state_q, state_d;
    logic [RCW-1:0]             row_cnt_q, row_cnt_d;
    logic                       armed_q, armed_d;
    logic [DATAWIDTH_BUS-1:0]   result_q, result_d;
    logic                       reg_reset_q, reg_reset_d;
    logic [NUM_ROWS-1:0]        load_n_q, load_n_d;
    logic                       cnn_start_q, cnn_start_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;

`ifdef CNN_CTRL_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYC);
    // ERR is entered when the count would step onto TIMEOUT_CYC-1, so a run
    // with no done raises Error exactly TIMEOUT_CYC cycles after CNNStart.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 2);
    logic [WCW-1:0]             wait_cnt_q, wait_cnt_d;
`endif

    logic cmd_hit, trigger;
    assign cmd_hit = (CNNCtrl_Cmd_InBUS == START_CODE);
    // A held command fires once: armed only returns after a non-start byte.
    assign trigger = cmd_hit && armed_q;

    // State, counters and registered outputs
    always_ff @(posedge CNNCtrl_CLOCK_50 or posedge CNNCtrl_Reset_InHigh) begin
        if (CNNCtrl_Reset_InHigh) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            armed_q     <= 1'b1;
            result_q    <= '0;
            reg_reset_q <= 1'b0;
            load_n_q    <= '1;
            cnn_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef CNN_CTRL_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            armed_q     <= armed_d;
            result_q    <= result_d;
            reg_reset_q <= reg_reset_d;
            load_n_q    <= load_n_d;
            cnn_start_q <= cnn_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef CNN_CTRL_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    // Next-state, row/wait counters, arming and result capture
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        armed_d   = !cmd_hit;
        result_d  = result_q;
`ifdef CNN_CTRL_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (trigger) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d   = S_LOAD;
                row_cnt_d = '0;
            end
            S_LOAD: begin
                // Counter parks on the last row rather than wrapping.
                if (row_cnt_q == ROW_LAST) state_d   = S_START;
                else                       row_cnt_d = row_cnt_q + RCW'(1);
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef CNN_CTRL_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
`ifdef CNN_CTRL_TIMEOUT_EN
                wait_cnt_d = wait_cnt_q + WCW'(1);
`endif
                // Done on the final count still wins over the timeout.
                if (CNNCtrl_CNNDone_In) begin
                    state_d  = S_DONE;
                    result_d = CNNCtrl_Predict_InBUS;
                end
`ifdef CNN_CTRL_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they come straight from flops
    always_comb begin
        reg_reset_d = (state_d == S_CLEAR);
        cnn_start_d = (state_d == S_START);
        busy_d      = (state_d == S_CLEAR) || (state_d == S_LOAD) ||
                      (state_d == S_START) || (state_d == S_WAIT);
        done_d      = (state_d == S_DONE);
`ifdef CNN_CTRL_TIMEOUT_EN
        error_d     = (state_d == S_ERR);
`else
        error_d     = 1'b0;
`endif
        load_n_d    = '1;
        for (int i = 0; i < NUM_ROWS; i++) begin
            load_n_d[i] = !((state_d == S_LOAD) && (row_cnt_d == RCW'(i)));
        end
    end

    assign CNNCtrl_RegReset_InHigh = reg_reset_q;
    assign CNNCtrl_Load_InLow      = load_n_q;
    assign CNNCtrl_CNNStart_Out    = cnn_start_q;
    assign CNNCtrl_Busy_Out        = busy_q;
    assign CNNCtrl_Done_Out        = done_q;
    assign CNNCtrl_Error_Out       = error_q;
    assign CNNCtrl_Result_OutBUS   = result_q;

endmodule

// File: tb/tb_cnn_row_load_ctrl.sv
// Scoreboard bench for cnn_row_load_ctrl: each trigger pushes the expected
// clear/load/start sequence, each done (or timeout) pushes the expected
// completion; a negedge monitor pops and compares as the DUT acts.
module tb_cnn_row_load_ctrl;
    localparam int DW = 8;
    localparam int NR = 8;
`ifdef CNN_CTRL_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] cmd, pred;
    logic          cnn_done;
    logic          reg_rst, cnn_start, busy, done_o, err_o;
    logic [NR-1:0] load_n;
    logic [DW-1:0] result;

    cnn_row_load_ctrl #(.DATAWIDTH_BUS(DW), .NUM_ROWS(NR), .START_CODE(8'hA5),
                        .TIMEOUT_CYC(TO)) dut (
        .CNNCtrl_CLOCK_50        (clk),
        .CNNCtrl_Reset_InHigh    (rst),
        .CNNCtrl_Cmd_InBUS       (cmd),
        .CNNCtrl_CNNDone_In      (cnn_done),
        .CNNCtrl_Predict_InBUS   (pred),
        .CNNCtrl_RegReset_InHigh (reg_rst),
        .CNNCtrl_Load_InLow      (load_n),
        .CNNCtrl_CNNStart_Out    (cnn_start),
        .CNNCtrl_Busy_Out        (busy),
        .CNNCtrl_Done_Out        (done_o),
        .CNNCtrl_Error_Out       (err_o),
        .CNNCtrl_Result_OutBUS   (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic rr; logic [NR-1:0] ld; logic st; } act_t;
    typedef struct { int cyc; logic [DW-1:0] res; logic err; } res_t;
    act_t act_q[$];
    res_t res_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected activity for a trigger sampled at the end of cycle t
    task automatic push_run(input int t);
        act_t a;
        a.cyc = t + 1; a.rr = 1'b1; a.ld = '1; a.st = 1'b0;
        act_q.push_back(a);
        for (int r = 0; r < NR; r++) begin
            a.cyc = t + 2 + r; a.rr = 1'b0; a.ld = '1; a.ld[r] = 1'b0; a.st = 1'b0;
            act_q.push_back(a);
        end
        a.cyc = t + 2 + NR; a.rr = 1'b0; a.ld = '1; a.st = 1'b1;
        act_q.push_back(a);
    endtask

    task automatic push_res(input int c, input logic [DW-1:0] v, input logic e);
        res_t r;
        r.cyc = c; r.res = v; r.err = e;
        res_q.push_back(r);
    endtask

    logic done_prev = 1'b0;
    logic err_prev  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_rst || (load_n != '1) || cnn_start) begin
                if (act_q.size() == 0) begin
                    chk("unexpected_act", {22'd0, reg_rst, cnn_start, load_n},
                        {22'd0, 2'b00, {NR{1'b1}}});
                end else begin
                    act_t a;
                    a = act_q.pop_front();
                    chk("act_cyc",   cyc,       a.cyc);
                    chk("act_rr",    reg_rst,   a.rr);
                    chk("act_load",  load_n,    a.ld);
                    chk("act_start", cnn_start, a.st);
                end
            end
            if ((done_o && !done_prev) || (err_o && !err_prev)) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_end", {done_o, err_o}, 2'b00);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("end_cyc",  cyc,    r.cyc);
                    chk("end_res",  result, r.res);
                    chk("end_err",  err_o,  r.err);
                    chk("end_done", done_o, !r.err);
                    chk("end_busy", busy,   1'b0);
                end
            end
        end
        done_prev <= done_o;
        err_prev  <= err_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1; cmd = '0; pred = '0; cnn_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regreset", reg_rst,   1'b0);
        chk("rst_load",     load_n,    8'hFF);
        chk("rst_start",    cnn_start, 1'b0);
        chk("rst_busy",     busy,      1'b0);
        chk("rst_done",     done_o,    1'b0);
        chk("rst_err",      err_o,     1'b0);
        chk("rst_result",   result,    8'h00);
        rst = 1'b0;
        tick();

        // Single-cycle command, done 5 cycles after start
        cmd = 8'hA5; t = cyc; push_run(t);
        tick(); cmd = '0;
        chk("busy_in_clear", busy, 1'b1);
        while (cyc < t + 15) tick();
        cnn_done = 1'b1; pred = 8'h07; push_res(t + 16, 8'h07, 1'b0);
        tick(); cnn_done = 1'b0; pred = '0;
        chk("done_busy", busy, 1'b0);
        chk("done_lvl",  done_o, 1'b1);
        chk("done_res",  result, 8'h07);

        // Held command: one run only, re-arm after a non-start byte
        tick();
        cmd = 8'hA5; t = cyc; push_run(t);
        repeat (12) tick();
        cnn_done = 1'b1; pred = 8'h42; push_res(t + 13, 8'h42, 1'b0);
        tick(); cnn_done = 1'b0;
        repeat (37) tick();
        chk("held_done", done_o, 1'b1);
        chk("held_busy", busy, 1'b0);
        cmd = 8'h00; tick();
        cmd = 8'hA5; t = cyc; push_run(t);
        tick(); cmd = '0;
        chk("clear_drops_done", done_o, 1'b0);
        tick();
        chk("result_hold_load", result, 8'h42);
        while (cyc < t + 12) tick();
        cnn_done = 1'b1; pred = 8'h19; push_res(t + 13, 8'h19, 1'b0);
        tick(); cnn_done = 1'b0;

        // Retrigger and done during LOAD row 3 are ignored
        tick();
        cmd = 8'hA5; t = cyc; push_run(t);
        tick(); cmd = '0;
        while (cyc < t + 5) tick();
        cmd = 8'hA5; cnn_done = 1'b1; pred = 8'hEE;
        tick(); cmd = '0; cnn_done = 1'b0;
        while (cyc < t + 14) tick();
        chk("no_early_done", done_o, 1'b0);
        cnn_done = 1'b1; pred = 8'h5A; push_res(t + 15, 8'h5A, 1'b0);
        tick(); cnn_done = 1'b0;

        // Async reset in WAIT, then a normal run
        tick();
        cmd = 8'hA5; t = cyc; push_run(t);
        tick(); cmd = '0;
        while (cyc < t + 13) tick();
        chk("wait_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",   busy,    1'b0);
        chk("arst_load",   load_n,  8'hFF);
        chk("arst_result", result,  8'h00);
        chk("arst_rr",     reg_rst, 1'b0);
        tick(); rst = 1'b0;
        tick();
        cmd = 8'hA5; t = cyc; push_run(t);
        tick(); cmd = '0;
        while (cyc < t + 11) tick();
        cnn_done = 1'b1; pred = 8'h3C; push_res(t + 12, 8'h3C, 1'b0);
        tick(); cnn_done = 1'b0;

`ifdef CNN_CTRL_TIMEOUT_EN
        // No done: ERR 16 cycles after start, result kept, retrigger clears
        tick();
        cmd = 8'hA5; t = cyc; push_run(t);
        push_res(t + 2 + NR + TO, 8'h3C, 1'b1);
        tick(); cmd = '0;
        while (cyc < t + 30) tick();
        chk("to_err",    err_o,  1'b1);
        chk("to_result", result, 8'h3C);
        cmd = 8'hA5; t = cyc; push_run(t);
        tick(); cmd = '0;
        chk("to_err_clear", err_o, 1'b0);
        while (cyc < t + 11) tick();
        cnn_done = 1'b1; pred = 8'h77; push_res(t + 12, 8'h77, 1'b0);
        tick(); cnn_done = 1'b0;
`endif

        repeat (5) tick();
        chk("act_q_empty", act_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
